// File: rtl/multicycle_control.sv
// Multi-cycle main control unit for the RV64 datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB from the opcode, drives datapath
// enables and ALUOp, and counts retired instructions.
//
// Handshake: memory is a simple request/strobe pair. MemRead or MemWrite is
// held high for the whole access; the access completes on the first rising
// edge where MemReady=1 while in FETCH, MEM_READ or MEM_WRITE. MemReady in any
// other state has no effect.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ILLEGAL   = 4'd9
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    assign State      = state_q;
    assign InstrCount = count_q;

    // State register and retired-instruction counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Next-state, retire strobe and Moore outputs (IRWrite/PCWrite are Mealy on MemReady in FETCH).
    always_comb begin
        state_d     = S_FETCH;
        retire      = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 1'b0;
        Illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // No instruction load or PC advance may leak out during reset.
                IRWrite = MemReady & ~reset;
                PCWrite = MemReady & ~reset;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_LD, OP_SD: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Only LD/SD reach here; anything else falls back to FETCH.
                if (Opcode == OP_LD) begin
                    state_d = S_MEM_READ;
                end else if (Opcode == OP_SD) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = MemReady;
                state_d  = MemReady ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b00;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: begin
                Illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unused encodings: all outputs stay 0, recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (instantiated with CNT_W=4 so the
// retired-instruction counter wrap is reachable in a short run).
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [6:0]       Opcode;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             PCSource;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    int checks;
    int failures;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .Illegal    (Illegal),
        .State      (State),
        .InstrCount (InstrCount)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge; inputs are changed and outputs sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemReady = 1'b1; Opcode = 7'b0110011;
        step(); step();
        #1;
        checks++; if (IRWrite !== 1'b0) begin failures++; $display("FAIL rst_irwrite_forced got=%b exp=0", IRWrite); end
        checks++; if (PCWrite !== 1'b0) begin failures++; $display("FAIL rst_pcwrite_forced got=%b exp=0", PCWrite); end
        reset = 1'b0; MemReady = 1'b0;
        #1;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", State); end
        checks++; if (InstrCount !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", InstrCount); end
        checks++; if ({MemRead, ALUSrcB, ALUOp, IRWrite, PCWrite, MemWrite} !== 8'b1_01_00_000) begin
            failures++; $display("FAIL rst_fetch_outputs got=%b exp=10100000", {MemRead, ALUSrcB, ALUOp, IRWrite, PCWrite, MemWrite}); end
        // Waiting in FETCH without MemReady holds the state.
        step();
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL fetch_wait_state got=%0d exp=0", State); end
    endtask

    task automatic test_rtype();
        Opcode = 7'b0110011; MemReady = 1'b1;
        #1;
        checks++; if ({IRWrite, PCWrite} !== 2'b11) begin failures++; $display("FAIL rt_fetch_irpc got=%b exp=11", {IRWrite, PCWrite}); end
        step();
        checks++; if (State !== 4'd1) begin failures++; $display("FAIL rt_decode_state got=%0d exp=1", State); end
        checks++; if ({ALUSrcB, ALUOp, MemRead, IRWrite} !== 6'b11_00_00) begin failures++; $display("FAIL rt_decode_out got=%b exp=110000", {ALUSrcB, ALUOp, MemRead, IRWrite}); end
        step();
        checks++; if (State !== 4'd6) begin failures++; $display("FAIL rt_exec_state got=%0d exp=6", State); end
        checks++; if ({ALUOp, ALUSrcA, ALUSrcB, RegWrite} !== 6'b10_1_00_0) begin failures++; $display("FAIL rt_exec_out got=%b exp=101000", {ALUOp, ALUSrcA, ALUSrcB, RegWrite}); end
        step();
        checks++; if (State !== 4'd7) begin failures++; $display("FAIL rt_wb_state got=%0d exp=7", State); end
        checks++; if ({RegWrite, MemtoReg} !== 2'b10) begin failures++; $display("FAIL rt_wb_out got=%b exp=10", {RegWrite, MemtoReg}); end
        checks++; if (InstrCount !== 4'd0) begin failures++; $display("FAIL rt_count_before got=%0d exp=0", InstrCount); end
        step();
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL rt_back_fetch got=%0d exp=0", State); end
        checks++; if (InstrCount !== 4'd1) begin failures++; $display("FAIL rt_count got=%0d exp=1", InstrCount); end
    endtask

    task automatic test_ld_wait();
        int cycles;
        Opcode = 7'b0000011; MemReady = 1'b1; cycles = 0;
        step(); cycles++;
        step(); cycles++;
        checks++; if (State !== 4'd2) begin failures++; $display("FAIL ld_addr_state got=%0d exp=2", State); end
        checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== 5'b1_10_00) begin failures++; $display("FAIL ld_addr_out got=%b exp=11000", {ALUSrcA, ALUSrcB, ALUOp}); end
        step(); cycles++;
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({State, MemRead, IorD, MemWrite} !== 7'b0011_110) begin
                failures++; $display("FAIL ld_read_wait%0d got=%b exp=0011110", i, {State, MemRead, IorD, MemWrite}); end
            step(); cycles++;
        end
        MemReady = 1'b1;
        #1;
        checks++; if ({State, MemRead, IorD} !== 6'b0011_11) begin failures++; $display("FAIL ld_read_done got=%b exp=001111", {State, MemRead, IorD}); end
        step(); cycles++;
        checks++; if ({State, RegWrite, MemtoReg} !== 6'b0100_11) begin failures++; $display("FAIL ld_wb got=%b exp=010011", {State, RegWrite, MemtoReg}); end
        step(); cycles++;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL ld_back_fetch got=%0d exp=0", State); end
        checks++; if (cycles !== 8) begin failures++; $display("FAIL ld_cycles got=%0d exp=8", cycles); end
        checks++; if (InstrCount !== 4'd2) begin failures++; $display("FAIL ld_count got=%0d exp=2", InstrCount); end
    endtask

    task automatic test_beq();
        Opcode = 7'b1100011; MemReady = 1'b1;
        step(); step();
        checks++; if (State !== 4'd8) begin failures++; $display("FAIL beq_state got=%0d exp=8", State); end
        checks++; if ({ALUOp, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, PCWrite} !== 8'b01_1_1_1_00_0) begin
            failures++; $display("FAIL beq_out got=%b exp=01111000", {ALUOp, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, PCWrite}); end
        step();
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL beq_back_fetch got=%0d exp=0", State); end
        checks++; if (InstrCount !== 4'd3) begin failures++; $display("FAIL beq_count got=%0d exp=3", InstrCount); end
    endtask

    task automatic test_illegal();
        Opcode = 7'b1111111; MemReady = 1'b1;
        step();
        checks++; if (Illegal !== 1'b0) begin failures++; $display("FAIL ill_decode_pulse got=%b exp=0", Illegal); end
        step();
        checks++; if ({State, Illegal} !== 5'b1001_1) begin failures++; $display("FAIL ill_state got=%b exp=10011", {State, Illegal}); end
        step();
        checks++; if ({State, Illegal} !== 5'b0000_0) begin failures++; $display("FAIL ill_after got=%b exp=00000", {State, Illegal}); end
        checks++; if (InstrCount !== 4'd3) begin failures++; $display("FAIL ill_count got=%0d exp=3", InstrCount); end
    endtask

    task automatic test_sd();
        Opcode = 7'b0100011; MemReady = 1'b1;
        step(); step(); step();
        checks++; if ({State, MemWrite, IorD, MemRead} !== 7'b0101_110) begin failures++; $display("FAIL sd_write got=%b exp=0101110", {State, MemWrite, IorD, MemRead}); end
        step();
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL sd_back_fetch got=%0d exp=0", State); end
        checks++; if (InstrCount !== 4'd4) begin failures++; $display("FAIL sd_count got=%0d exp=4", InstrCount); end
    endtask

    task automatic test_sd_reset();
        Opcode = 7'b0100011; MemReady = 1'b1;
        step(); step(); step();
        MemReady = 1'b0;
        step(); step();
        checks++; if ({State, MemWrite, MemRead} !== 6'b0101_10) begin failures++; $display("FAIL sdr_wait got=%b exp=010110", {State, MemWrite, MemRead}); end
        // Reset together with a completing MemReady: reset must win.
        reset = 1'b1; MemReady = 1'b1;
        step();
        reset = 1'b0; MemReady = 1'b0;
        #1;
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL sdr_state got=%0d exp=0", State); end
        checks++; if (MemWrite !== 1'b0) begin failures++; $display("FAIL sdr_memwrite got=%b exp=0", MemWrite); end
        checks++; if (InstrCount !== 4'd0) begin failures++; $display("FAIL sdr_count got=%0d exp=0", InstrCount); end
    endtask

    task automatic test_wrap();
        Opcode = 7'b0110011; MemReady = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step(); step(); step(); step();
            if (n == 15) begin
                checks++; if (InstrCount !== 4'd15) begin failures++; $display("FAIL wrap_15 got=%0d exp=15", InstrCount); end
            end
        end
        checks++; if (InstrCount !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", InstrCount); end
        checks++; if (State !== 4'd0) begin failures++; $display("FAIL wrap_state got=%0d exp=0", State); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; MemReady = 1'b0; Opcode = 7'd0;
        @(negedge clk);
        test_reset();
        test_rtype();
        test_ld_wait();
        test_beq();
        test_illegal();
        test_sd();
        test_sd_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
